// File: rtl/apb_sram_pkg.sv
// apb_sram_pkg: FSM state type and width helpers shared by the APB SRAM controller and its byte-lane memory
package apb_sram_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_e;
  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction
  function automatic int cnt_width(input int ws);
    return ws > 0 ? $clog2(ws + 1) : 1;
  endfunction
endpackage

// File: rtl/apb_sram_bytemem.sv
// apb_sram_bytemem: DEPTH x DATA_WIDTH array, per-byte write enables (we_i/waddr_i/wdata_i), sync read (re_i/raddr_i -> rdata_o held until next re_i)
module apb_sram_bytemem import apb_sram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int MAW = 6
) (
  input  logic                              clk_i,
  input  logic [strb_width(DATA_WIDTH)-1:0] we_i,
  input  logic [MAW-1:0]                    waddr_i,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  input  logic                              re_i,
  input  logic [MAW-1:0]                    raddr_i,
  output logic [DATA_WIDTH-1:0]             rdata_o
);
  localparam int SW = strb_width(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < SW; i++)
      if (we_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/apb4_sram_ctrl.sv
// apb4_sram_ctrl: APB4 slave SRAM with wait states; PCLK/PRESET clock and async reset, PSEL..PSTRB request, PRDATA/PREADY/PSLVERR response
module apb4_sram_ctrl import apb_sram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                              PCLK,
  input  logic                              PRESET,
  input  logic                              PSEL,
  input  logic                              PENABLE,
  input  logic                              PWRITE,
  input  logic [ADDR_WIDTH-1:0]             PADDR,
  input  logic [DATA_WIDTH-1:0]             PWDATA,
  input  logic [strb_width(DATA_WIDTH)-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]             PRDATA,
  output logic                              PREADY,
  output logic                              PSLVERR
);
  localparam int SW = strb_width(DATA_WIDTH);
  localparam int OFF = $clog2(SW);
  localparam int CW = cnt_width(WAIT_STATES);
  localparam int MAW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CMPW = ADDR_WIDTH + 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MAW-1:0] addr_q;
  logic wr_q, oor_q, rsel_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic oor, setup, done, abort;
  logic [DATA_WIDTH-1:0] mem_rdata;
  assign idx = PADDR >> OFF;
  assign oor = CMPW'(idx) >= CMPW'(DEPTH);
  assign setup = state_q == IDLE && PSEL && !PENABLE;
  assign PREADY = state_q == ACCESS && cnt_q == '0;
  assign done = PREADY && PSEL && PENABLE;
  assign abort = state_q == ACCESS && !PSEL;
  assign PSLVERR = PREADY && oor_q;
  // rsel_q gates the memory's held read word so reset and out-of-range reads show zero
  assign PRDATA = rsel_q ? mem_rdata : '0;
  always_comb begin
    state_d = setup ? ACCESS : (done || abort) ? IDLE : state_q;
    cnt_d = setup ? CW'(WAIT_STATES) : (state_q == ACCESS && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      oor_q <= 1'b0;
      rsel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (setup) begin
        addr_q <= idx[MAW-1:0];
        wr_q <= PWRITE;
        oor_q <= oor;
        if (!PWRITE) rsel_q <= !oor;
      end
    end
  end
  apb_sram_bytemem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .MAW(MAW)) u_mem (
    .clk_i  (PCLK),
    .we_i   ((done && wr_q && !oor_q) ? PSTRB : '0),
    .waddr_i(addr_q),
    .wdata_i(PWDATA),
    .re_i   (setup && !PWRITE && !oor),
    .raddr_i(idx[MAW-1:0]),
    .rdata_o(mem_rdata)
  );
endmodule

// File: tb/tb_apb4_sram_ctrl.sv
// tb_apb4_sram_ctrl: scoreboard bench for apb4_sram_ctrl (WAIT_STATES=2 and WAIT_STATES=0 instances)
module tb_apb4_sram_ctrl;
  typedef struct {
    logic        chk;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic sel0 = 1'b0, sel1 = 1'b0, en = 1'b0, wr = 1'b0;
  logic [7:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] strb = '0;
  logic [31:0] rd0, rd1;
  logic rdy0, rdy1, err0, err1;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int checks = 0, errors = 0, acc0 = 0, acc1 = 0;
  longint t0, t1;
  always #5 PCLK = ~PCLK;
  apb4_sram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(48), .WAIT_STATES(2)) u0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(sel0), .PENABLE(en), .PWRITE(wr), .PADDR(addr),
    .PWDATA(wdata), .PSTRB(strb), .PRDATA(rd0), .PREADY(rdy0), .PSLVERR(err0));
  apb4_sram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(48), .WAIT_STATES(0)) u1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(sel1), .PENABLE(en), .PWRITE(wr), .PADDR(addr),
    .PWDATA(wdata), .PSTRB(strb), .PRDATA(rd1), .PREADY(rdy1), .PSLVERR(err1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic apb(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic chkrd, input logic [31:0] erd,
                     input logic eerr, input int ecyc);
    int n = 0;
    if (d == 0) q0.push_back('{chkrd, erd, eerr, ecyc});
    else q1.push_back('{chkrd, erd, eerr, ecyc});
    sel0 = d == 0; sel1 = d == 1; en = 1'b0; wr = w; addr = a; wdata = wd; strb = st;
    @(posedge PCLK); #1 en = 1'b1;
    do begin
      @(negedge PCLK);
      n++;
    end while (!(d == 0 ? rdy0 : rdy1) && n < 20);
    if (!(d == 0 ? rdy0 : rdy1)) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d addr %h got no PREADY want PREADY within 20 cycles", d, a);
    end
    @(posedge PCLK); #1 sel0 = 1'b0; sel1 = 1'b0; en = 1'b0;
  endtask
  task automatic idle();
    @(posedge PCLK); #1;
  endtask
  always @(negedge PCLK) begin
    if (sel0 && en) begin
      acc0++;
      if (rdy0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready0 got PREADY want none");
        end else begin
          e0 = q0.pop_front();
          chk("cycles0", acc0, e0.cyc);
          chk("slverr0", {31'd0, err0}, {31'd0, e0.err});
          if (e0.chk) chk("prdata0", rd0, e0.rd);
        end
        acc0 = 0;
      end
    end else acc0 = 0;
  end
  always @(negedge PCLK) begin
    if (sel1 && en) begin
      acc1++;
      if (rdy1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready1 got PREADY want none");
        end else begin
          e1 = q1.pop_front();
          chk("cycles1", acc1, e1.cyc);
          chk("slverr1", {31'd0, err1}, {31'd0, e1.err});
          if (e1.chk) chk("prdata1", rd1, e1.rd);
        end
        acc1 = 0;
      end
    end else acc1 = 0;
  end
  initial begin
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_prdata", rd0, 32'h0);
    chk("rst_pready", {31'd0, rdy0}, 32'h0);
    chk("rst_pslverr", {31'd0, err0}, 32'h0);
    PRESET = 1'b0;
    idle();
    apb(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0, 3);
    idle();
    apb(0, 0, 8'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0, 3);
    idle();
    apb(0, 1, 8'h10, 32'h11223344, 4'h5, 0, 32'h0, 0, 3);
    idle();
    apb(0, 0, 8'h10, 32'h0, 4'h0, 1, 32'hDE22BE44, 0, 3);
    idle();
    apb(0, 1, 8'hBC, 32'h12345678, 4'hF, 0, 32'h0, 0, 3);
    idle();
    apb(0, 1, 8'hC0, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1, 3);
    idle();
    apb(0, 0, 8'hC0, 32'h0, 4'h0, 1, 32'h0, 1, 3);
    idle();
    apb(0, 0, 8'hBC, 32'h0, 4'h0, 1, 32'h12345678, 0, 3);
    apb(0, 1, 8'h10, 32'h0, 4'h0, 0, 32'h0, 0, 3);
    chk("prdata_kept_after_write", rd0, 32'h12345678);
    apb(0, 0, 8'h10, 32'h0, 4'h0, 1, 32'hDE22BE44, 0, 3);
    idle();
    apb(0, 1, 8'h20, 32'hCAFEF00D, 4'hF, 0, 32'h0, 0, 3);
    idle();
    sel0 = 1'b1; en = 1'b0; wr = 1'b1; addr = 8'h20; wdata = 32'h0BAD0BAD; strb = 4'hF;
    @(posedge PCLK); #1 en = 1'b1;
    @(posedge PCLK); #1 sel0 = 1'b0; en = 1'b0;
    @(posedge PCLK); #1;
    chk("abort_idle_pready", {31'd0, rdy0}, 32'h0);
    chk("abort_prdata_kept", rd0, 32'hDE22BE44);
    apb(0, 0, 8'h20, 32'h0, 4'h0, 1, 32'hCAFEF00D, 0, 3);
    idle();
    sel0 = 1'b1; en = 1'b0; wr = 1'b0; addr = 8'h10;
    @(posedge PCLK); #1 en = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    chk("mid_pready", {31'd0, rdy0}, 32'h1);
    chk("mid_prdata", rd0, 32'hDE22BE44);
    PRESET = 1'b1;
    #1;
    chk("midrst_pready", {31'd0, rdy0}, 32'h0);
    chk("midrst_prdata", rd0, 32'h0);
    chk("midrst_pslverr", {31'd0, err0}, 32'h0);
    sel0 = 1'b0; en = 1'b0;
    idle();
    PRESET = 1'b0;
    idle();
    apb(0, 0, 8'h10, 32'h0, 4'h0, 1, 32'hDE22BE44, 0, 3);
    idle();
    apb(0, 0, 8'h20, 32'h0, 4'h0, 1, 32'hCAFEF00D, 0, 3);
    idle();
    t0 = $time;
    apb(1, 1, 8'h00, 32'h000000A5, 4'hF, 0, 32'h0, 0, 1);
    apb(1, 0, 8'h00, 32'h0, 4'h0, 1, 32'h000000A5, 0, 1);
    t1 = $time;
    chk("b2b_time", 32'(t1 - t0), 32'd40);
    idle();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/apb4_sram_ctrl.md
APB4_SRAM_CTRL -- requirements
Module: apb4_sram_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width; multiple of 8, range 8..64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: PADDR width; byte address.
REQ-003 SHALL have parameter DEPTH, default 64: number of words; must be no more than 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 SHALL have parameter WAIT_STATES, default 0: extra access-phase cycles before PREADY; range 0..15.
REQ-005 SHALL have port PCLK, input, 1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port PRESET, input, 1: reset; asynchronous, active-high.
REQ-007 SHALL have port PSEL, input, 1: slave select.
REQ-008 SHALL have port PENABLE, input, 1: access phase.
REQ-009 SHALL have port PWRITE, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port PADDR, input, ADDR_WIDTH: byte address.
REQ-011 SHALL have port PWDATA, input, DATA_WIDTH: write data.
REQ-012 SHALL have port PSTRB, input, DATA_WIDTH/8: byte-lane write strobes.
REQ-013 SHALL have port PRDATA, output, DATA_WIDTH: read data.
REQ-014 SHALL have port PREADY, output, 1: transfer complete.
REQ-015 SHALL have port PSLVERR, output, 1: transfer error; valid only while PREADY is high.

Function
REQ-016 SHALL compute word index = PADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; byte-offset bits are ignored (no misalignment error).
REQ-017 SHALL use a 2-state FSM: IDLE and ACCESS.
- IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase).
- At that edge: capture word index, PWRITE and the out-of-range flag (index >= DEPTH); load the wait counter with WAIT_STATES.
REQ-018 SHALL, in ACCESS, decrement the wait counter each cycle while it is nonzero; PREADY = (state==ACCESS && counter==0), combinational.
REQ-019 SHALL return ACCESS -> IDLE at the edge where PREADY=1 and PSEL=PENABLE=1.
REQ-020 SHALL return ACCESS -> IDLE with no memory write if PSEL=0 in ACCESS (aborted transfer).
REQ-021 SHALL hold ACCESS (no transition) if PSEL=1 and PENABLE=0 while in ACCESS (protocol violation).
REQ-022 SHALL write at the completion edge (REQ-019) for in-range writes only: each byte lane i is updated only where PSTRB[i]=1; PSTRB=0 gives a successful no-op.
REQ-023 SHALL issue the synchronous read at the setup edge for in-range reads; PRDATA holds that word from the following cycle until the next read setup edge, so total latency is WAIT_STATES+1 cycles after setup.
REQ-024 SHALL, for out-of-range reads, load PRDATA with 0.
REQ-025 SHALL assert PSLVERR = PREADY && captured out-of-range flag; out-of-range writes are suppressed.
REQ-026 SHALL support back-to-back transfers: a setup phase in the cycle immediately after completion is accepted, giving zero idle cycles.
REQ-027 SHALL update PRDATA only on read setups; writes and aborts leave it unchanged.

Reset
REQ-028 SHALL, while PRESET=1, force: state IDLE, counter 0, PRDATA 0, PREADY 0, PSLVERR 0.
REQ-029 SHALL NOT clear memory contents on reset; a reset mid-transfer cancels the transfer with no write.

Structure
REQ-030 SHALL place the FSM state enum and the WAIT_STATES/strobe-width helper constants in package apb_sram_pkg.
REQ-031 SHALL instantiate one sub-module, apb_sram_bytemem: DEPTH x DATA_WIDTH, synchronous read port, per-byte write enables, no reset on the array.
REQ-032 SHALL size the wait counter as $clog2(WAIT_STATES+1), minimum 1 bit.

Verification (DATA_WIDTH=32, ADDR_WIDTH=8, DEPTH=48, WAIT_STATES=2 unless noted)
REQ-033 SHALL check a write then a read: write 0xDEADBEEF to 0x10 with PSTRB=0xF, then read 0x10 -> PREADY on the 3rd access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-034 SHALL check byte strobes: write 0x11223344 with PSTRB=0x5 over 0xDEADBEEF at 0x10 -> read returns 0xDE22BE44.
REQ-035 SHALL check out-of-range access at 0xC0 (index 48): write then read -> PSLVERR=1 with PREADY, PRDATA=0, and word 47 unchanged.
REQ-036 SHALL check back-to-back with WAIT_STATES=0: write 0xA5 to 0x00, then read 0x00 immediately -> each transfer takes 2 cycles, PRDATA=0x000000A5.
REQ-037 SHALL check abort: drop PSEL in access cycle 1 of a write -> FSM returns to IDLE and the old data is retained.
REQ-038 SHALL check reset mid-transfer: assert PRESET during a read's access phase -> PREADY, PRDATA and PSLVERR are 0 immediately, and memory contents are preserved.
